// File: rtl/multi_delay_timer.sv
// Purpose: CHANNELS independent ms delay timers (one-shot or periodic) with sticky done and done_pulse.
// Latency: start at edge N -> busy from N, expiry registered at N + max(dur,1)*TICKS_PER_MS.
// Backpressure: none; start/cancel are level-sampled strobes, start > cancel > counting per channel.
module multi_delay_timer #(
    parameter int TICKS_PER_MS = 250000,
    parameter int CHANNELS     = 4,
    parameter int DUR_WIDTH    = 11
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           start,
    input  logic [CHANNELS-1:0]           cancel,
    input  logic [CHANNELS-1:0]           periodic,
    input  logic [CHANNELS*DUR_WIDTH-1:0] duration,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS-1:0]           done,
    output logic [CHANNELS-1:0]           done_pulse
);

    // A single-cycle tick still needs a 1-bit counter so the reload path stays uniform.
    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0]    TICK_LOAD = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [TICK_W-1:0]    TICK_ONE  = TICK_W'(1);
    localparam logic [DUR_WIDTH-1:0] DUR_ONE   = DUR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            state_t                state_q, state_d;
            logic [TICK_W-1:0]     tick_q, tick_d;
            logic [DUR_WIDTH-1:0]  ms_q, ms_d;
            logic [DUR_WIDTH-1:0]  dur_q, dur_d;
            logic [DUR_WIDTH-1:0]  dur_in;
            logic                  mode_q, mode_d;
            logic                  done_q, done_d;
            logic                  pulse_q, pulse_d;

            assign dur_in = duration[g*DUR_WIDTH +: DUR_WIDTH];

            // Next-state and counter update: start beats cancel beats counting.
            always_comb begin
                state_d = state_q;
                tick_d  = tick_q;
                ms_d    = ms_q;
                dur_d   = dur_q;
                mode_d  = mode_q;
                done_d  = done_q;
                pulse_d = 1'b0;

                if (start[g]) begin
                    // Zero duration is promoted to 1 ms so the channel always counts.
                    dur_d   = (dur_in == '0) ? DUR_ONE : dur_in;
                    mode_d  = periodic[g];
                    tick_d  = TICK_LOAD;
                    ms_d    = dur_d - DUR_ONE;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end else if (cancel[g]) begin
                    if (state_q != ST_IDLE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end else begin
                    case (state_q)
                        ST_RUN: begin
                            if (tick_q != '0) begin
                                tick_d = tick_q - TICK_ONE;
                            end else if (ms_q != '0) begin
                                ms_d   = ms_q - DUR_ONE;
                                tick_d = TICK_LOAD;
                            end else begin
                                done_d  = 1'b1;
                                pulse_d = 1'b1;
                                if (mode_q) begin
                                    // Reload on the expiry edge itself keeps the period exact.
                                    tick_d = TICK_LOAD;
                                    ms_d   = dur_q - DUR_ONE;
                                end else begin
                                    state_d = ST_EXPIRED;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            // Channel state register with synchronous reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    tick_q  <= '0;
                    ms_q    <= '0;
                    dur_q   <= '0;
                    mode_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    tick_q  <= tick_d;
                    ms_q    <= ms_d;
                    dur_q   <= dur_d;
                    mode_q  <= mode_d;
                    done_q  <= done_d;
                    pulse_q <= pulse_d;
                end
            end

            assign busy[g]       = (state_q == ST_RUN);
            assign done[g]       = done_q;
            assign done_pulse[g] = pulse_q;
        end
    endgenerate

endmodule

// File: doc/multi_delay_timer.md
# multi_delay_timer

Multi-channel millisecond delay timer. It generalises the single-channel fixed-duration delay to `CHANNELS` independent channels. Each channel has a runtime-loaded duration, a one-shot or periodic mode, and a cancel input. Sequencing FSMs (motor step spacing, settle delays, LED/strobe timing) use it as a shared timing resource. Each channel reports a sticky `done` level and a one-cycle `done_pulse`.

## Interface
- `TICKS_PER_MS`, default 250000: clock cycles per millisecond tick, ≥1.
- `CHANNELS`, default 4: number of independent timer channels, ≥1.
- `DUR_WIDTH`, default 11: width of each channel's duration field, in ms.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all channels.
- `start`  in  CHANNELS  per-channel start/restart strobe; level-sampled each cycle.
- `cancel`  in  CHANNELS  per-channel abort strobe.
- `periodic`  in  CHANNELS  mode, sampled with `start`: 0 = one-shot, 1 = periodic.
- `duration`  in  CHANNELS*DUR_WIDTH  channel i uses bits `[i*DUR_WIDTH +: DUR_WIDTH]`, in ms, sampled with `start`.
- `busy`  out  CHANNELS  channel is counting (state RUN).
- `done`  out  CHANNELS  sticky expiry flag.
- `done_pulse`  out  CHANNELS  one-cycle strobe on every expiry.

## Operation
- Each channel holds:
  - a 3-state FSM: IDLE, RUN, EXPIRED;
  - `tick_cnt`, width `$clog2(TICKS_PER_MS)`, minimum 1;
  - `ms_left`, `DUR_WIDTH` bits;
  - latched `dur` and `mode`.
- Priority per channel, per cycle: `reset` > `start` > `cancel` > counting.
- `reset`: every channel goes to IDLE. All outputs are 0 and all counters are 0.
- `start[i]`, accepted in any state:
  - latch `dur` = duration, with 0 treated as 1;
  - latch `mode` = `periodic[i]`;
  - load `tick_cnt` = TICKS_PER_MS−1 and `ms_left` = `dur`−1;
  - clear `done[i]`; go to RUN.
  - A start during RUN restarts the channel cleanly, with no expiry and no pulse.
- `cancel[i]`:
  - RUN or EXPIRED → IDLE; clear `done[i]`; no pulse.
  - In IDLE it has no effect.
- Counting, in RUN only:
  - `tick_cnt` ≠ 0: decrement `tick_cnt`.
  - `tick_cnt` = 0 and `ms_left` ≠ 0: decrement `ms_left`; reload `tick_cnt` = TICKS_PER_MS−1.
  - `tick_cnt` = 0 and `ms_left` = 0 (expiry): set `done[i]` = 1 and `done_pulse[i]` = 1.
    - One-shot: go to EXPIRED.
    - Periodic: reload both counters from the latched `dur` and stay in RUN.
- EXPIRED holds `done` = 1 until the next start, cancel or reset.
- In periodic mode `done` stays 1 after the first expiry. `done_pulse` fires on every period.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Arithmetic is unsigned. Counters never wrap, because reload always occurs at 0.

## Timing
- All outputs are registered. Reset value of `busy`, `done` and `done_pulse` is 0.
- Start accepted at edge N:
  - `busy` = 1 from edge N.
  - Expiry is registered at edge N + D·T, where D = max(`dur`, 1) and T = TICKS_PER_MS.
  - `done`/`done_pulse` rise at edge N + D·T. `busy` falls at the same edge in one-shot mode.
- Periodic mode: pulses at edges N + k·D·T for k = 1, 2, …. Period is exact, with no cycle slip at reload.
- `done_pulse` is high for exactly one cycle, except consecutive periods when D·T = 1.
- Start and expiry on the same edge: start wins. No pulse; the count reloads.
- Cancel and expiry on the same edge: cancel wins. No pulse; `done` = 0.
- Start and cancel on the same edge: start wins.
- Holding `start` high keeps restarting the channel; it never expires while held.
- Reset mid-count aborts at that edge with no pulse.
- Minimum case D = 1, T = 1: expiry one cycle after start.

## Test plan
Bench parameters: TICKS_PER_MS = 4, CHANNELS = 2, DUR_WIDTH = 4.
- One-shot: ch0, duration 3, start at edge 10 → `busy` high on edges 10–21; `done`/`done_pulse` rise at edge 22; pulse low at edge 23; `done` stays high.
- Periodic: ch1, duration 2, periodic = 1, start at edge 0 → `done_pulse` at edges 8, 16, 24; `busy` stays 1; cancel at edge 26 → `busy` = 0, `done` = 0, no further pulses.
- Zero duration: duration 0 → behaves as 1; pulse at start + 4.
- Restart: ch0, duration 3, start at 0, second start at 6 → no pulse at 12; pulse at 18.
- Collisions:
  - ch0, duration 1, start at 0, cancel at 4 (the expiry edge) → no pulse, `done` = 0.
  - Restart at 4 instead → pulse at 8.
- Reset mid-count with channels independent:
  - Both channels running with different durations; `reset` at an arbitrary edge → all outputs 0 at the next cycle, no pulses.
  - After release, restarting ch0 does not disturb ch1 and vice versa.
